bitreader_prefetch: RTL

BITREADER_PREFETCH -- requirements
Module: bitreader_prefetch

---
 rtl/bitreader_prefetch.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/bitreader_prefetch.sv
// bitreader_prefetch: MSB-first bitstream reader with a word prefetch FIFO.
//
// Ports
//   aclk, aresetn           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only when idle)
//   cmd_op                  0 attach, 1 skip, 2 read, 3 peek
//   cmd_addr                attach byte address
//   cmd_bits                field length (read/peek) or skip length
//   cmd_signed              sign-extend read/peek result
//   rsp_valid/rsp_data      one-cycle result strobe, right-justified result
//   rsp_err                 sticky memory error since last attach, qualified by rsp_valid
//   busy                    command in progress
//   mem_*                   read-only memory request/grant/response interface
module bitreader_prefetch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_BITS   = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_bits,
    input  logic                    cmd_signed,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_rsp_rdata,
    input  logic                    mem_rsp_error
);

    localparam int unsigned BW   = 2 * DATA_WIDTH;
    localparam int unsigned CNTW = $clog2(BW + 256);
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned OW   = $clog2(DATA_WIDTH / 8);

    localparam logic [1:0] OpAttach = 2'd0;
    localparam logic [1:0] OpSkip   = 2'd1;
    localparam logic [1:0] OpRead   = 2'd2;
    localparam logic [1:0] OpPeek   = 2'd3;

    localparam logic [CNTW-1:0] DwCnt = CNTW'(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StDrain, StExec, StResp} state_e;

    state_e                 state_q;
    logic [1:0]             op_q;
    logic [7:0]             bits_q;
    logic                   sgn_q;
    logic                   attached_q;
    logic                   err_q;
    logic                   rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [CW-1:0]          outst_q;
    logic [CW-1:0]          count_q;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [BW-1:0]          buf_q;      // next stream bit sits at buf_q[BW-1]
    logic [CNTW-1:0]        level_q;
    logic [CNTW-1:0]        skip_q;     // bits still to discard (attach offset or skip)

    logic                   accept, attach_acc, grant, push, pop, done, bits_ok;
    logic [CW-1:0]          free_slots, count_d, outst_d;
    logic [CNTW-1:0]        cap, n_skip, n_cmd, n, lvl_fill, level_d, skip_d;
    logic [BW-1:0]          buf_fill, buf_d;
    logic [DATA_WIDTH-1:0]  fld_raw, field, ext_mask, rd_val, rsp_next;

    assign cmd_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign accept     = cmd_valid && cmd_ready;
    assign attach_acc = accept && (cmd_op == OpAttach);

    // Free-minus-outstanding never shrinks without a grant, so req stays up until granted.
    assign free_slots = CW'(FIFO_DEPTH) - count_q;
    assign mem_req    = attached_q && (state_q != StDrain) && (free_slots > outst_q);
    assign mem_addr   = addr_q;
    assign mem_we     = 1'b0;
    assign mem_wdata  = '0;
    assign mem_be     = '0;
    assign grant      = mem_req && mem_gnt;

    // Responses seen while draining (or on the attach cycle) belong to the old stream.
    assign push = mem_rsp_valid && (state_q != StDrain) && !attach_acc;
    assign pop  = (count_q != '0) && (level_q <= DwCnt);

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_valid_q && err_q;

    // Field extraction and optional sign extension.
    assign bits_ok  = (bits_q != 8'd0) && (32'(bits_q) <= MAX_BITS);
    assign fld_raw  = DATA_WIDTH'(buf_q[BW-1 -: MAX_BITS]);
    assign field    = fld_raw >> (MAX_BITS - 32'(bits_q));
    assign ext_mask = {DATA_WIDTH{1'b1}} << bits_q;
    assign rd_val   = field | ((sgn_q && buf_q[BW-1]) ? ext_mask : '0);
    assign rsp_next = ((op_q == OpRead || op_q == OpPeek) && bits_ok) ? rd_val : '0;

    always_comb begin
        n_cmd = '0;
        done  = 1'b0;
        // Pending discard drains in the background, at most one word per cycle.
        cap    = (skip_q > DwCnt) ? DwCnt : skip_q;
        n_skip = (cap > level_q) ? level_q : cap;
        if (state_q == StExec && attached_q) begin
            unique case (op_q)
                OpSkip: done = (skip_q == n_skip);
                OpRead, OpPeek: begin
                    if (!bits_ok) begin
                        done = 1'b1;
                    end else if (skip_q == '0 && level_q >= CNTW'(bits_q)) begin
                        done = 1'b1;
                        if (op_q == OpRead) n_cmd = CNTW'(bits_q);
                    end
                end
                default: done = 1'b0;
            endcase
        end
        n = n_skip + n_cmd;

        buf_fill = buf_q;
        lvl_fill = level_q;
        if (pop) begin
            buf_fill = buf_q | ({fifo_mem[rd_ptr_q], {DATA_WIDTH{1'b0}}} >> level_q);
            lvl_fill = level_q + DwCnt;
        end
        buf_d   = buf_fill << n;
        level_d = lvl_fill - n;

        skip_d = skip_q - n_skip;
        if (accept && cmd_op == OpSkip) skip_d = skip_d + CNTW'(cmd_bits);

        count_d = count_q + CW'(push) - CW'(pop);
        outst_d = outst_q + CW'(grant) - CW'(mem_rsp_valid && outst_q != '0);
    end

    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wr_ptr_q] <= mem_rsp_rdata;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            op_q        <= OpAttach;
            bits_q      <= '0;
            sgn_q       <= 1'b0;
            attached_q  <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            addr_q      <= '0;
            outst_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            buf_q       <= '0;
            level_q     <= '0;
            skip_q      <= '0;
        end else begin
            outst_q     <= outst_d;
            rsp_valid_q <= 1'b0;
            if (attach_acc) begin
                attached_q <= 1'b1;
                err_q      <= 1'b0;
                addr_q     <= {cmd_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
                count_q    <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                buf_q      <= '0;
                level_q    <= '0;
                skip_q     <= CNTW'(cmd_addr[OW-1:0]) << 3;
            end else begin
                if (grant) addr_q <= addr_q + ADDR_WIDTH'(DATA_WIDTH / 8);
                if (push && mem_rsp_error) err_q <= 1'b1;
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                count_q <= count_d;
                buf_q   <= buf_d;
                level_q <= level_d;
                skip_q  <= skip_d;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= cmd_op;
                        bits_q  <= cmd_bits;
                        sgn_q   <= cmd_signed;
                        state_q <= (cmd_op == OpAttach) ? StDrain : StExec;
                    end
                end
                StDrain: if (outst_q == '0) state_q <= StIdle;
                StExec: begin
                    if (done) begin
                        rsp_data_q  <= rsp_next;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
